// File: rtl/seg7_pattern_decoder_pkg.sv
// seg7_pattern_decoder_pkg: shared segment patterns, FSM encodings and lookup result type
package seg7_pattern_decoder_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_LOCK  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;
  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] digit;
  } lut_t;
endpackage

// File: rtl/seg7_pattern_decoder_if.sv
// seg7_pattern_decoder_if: segment pattern input and decoded digit status bundle
interface seg7_pattern_decoder_if;
  logic [6:0] seg_in;
  logic [3:0] value_out;
  logic       value_valid;
  logic       value_changed;
  logic       seg_error;
  logic       blank;
  modport master (output seg_in, input value_out, value_valid, value_changed, seg_error, blank);
  modport slave  (input seg_in, output value_out, value_valid, value_changed, seg_error, blank);
endinterface

// File: rtl/seg7_pattern_decoder_lut.sv
// seg7_pattern_decoder_lut: classifies an active-low segment pattern as digit, blank or illegal
module seg7_pattern_decoder_lut
  import seg7_pattern_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output lut_t       res
);
  // Pattern lookup; anything not listed stays illegal
  always_comb begin
    res = '{legal: 1'b0, is_blank: 1'b0, digit: 4'd0};
    case (pattern)
      SEG_0:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd0};
      SEG_1:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd1};
      SEG_2:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd2};
      SEG_3:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd3};
      SEG_4:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd4};
      SEG_5:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd5};
      SEG_6:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd6};
      SEG_7:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd7};
      SEG_8:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd8};
      SEG_9:     res = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd9};
      SEG_BLANK: res = '{legal: 1'b0, is_blank: 1'b1, digit: 4'd0};
      default:   ;
    endcase
  end
endmodule

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: synchronises, debounces and decodes an active-low 7-segment pattern
module seg7_pattern_decoder
  import seg7_pattern_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  seg7_pattern_decoder_if.slave  bus
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [6:0] s1, s2, s2_d;
  logic [CW-1:0] cnt;
  logic [1:0] state;
  logic same, commit;
  lut_t cls;
  seg7_pattern_decoder_lut u_lut (.pattern(s2), .res(cls));
  assign same = s2 == s2_d;
  // Commit once per stable run: only on the step into saturation
  assign commit = same && cnt == CMAX - CW'(1);
  // Two-flop synchroniser plus saturating stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 7'h7F;
      s2 <= 7'h7F;
      s2_d <= 7'h7F;
      cnt <= '0;
    end else begin
      s1 <= bus.seg_in;
      s2 <= s1;
      s2_d <= s2;
      cnt <= !same ? '0 : cnt == CMAX ? cnt : cnt + 1'b1;
    end
  end
  // Class FSM and registered outputs, updated only on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
      bus.value_out <= 4'd0;
      bus.value_valid <= 1'b0;
      bus.value_changed <= 1'b0;
      bus.seg_error <= 1'b0;
      bus.blank <= 1'b0;
    end else begin
      bus.value_changed <= 1'b0;
      if (commit) begin
        state <= cls.legal ? S_LOCK : cls.is_blank ? S_BLANK : S_ERR;
        bus.value_valid <= cls.legal;
        bus.seg_error <= !cls.legal && !cls.is_blank;
        bus.blank <= cls.is_blank;
        if (cls.legal) begin
          bus.value_out <= cls.digit;
          bus.value_changed <= state == S_WAIT || cls.digit != bus.value_out;
        end
      end
    end
  end
endmodule
